// File: rtl/mont_exp_pkg.sv
// mont_exp_pkg -- shared types for the Montgomery exponentiation sequencer.
//   state_t : sequencer FSM states
//   opsel_t : operand-pair select for the multiplier operand register
//   cnt_w() : width of the bits-remaining counter for a given exponent width
package mont_exp_pkg;

   typedef enum logic [3:0] {
      IDLE,
      SQR_ISSUE,
      SQR_WAIT,
      MUL_ISSUE,
      MUL_WAIT,
      FIN,
      CONV_ISSUE,
      CONV_WAIT,
      DONE
   } state_t;

   // SEL_RR: square R, SEL_RB: R times base, SEL_R1: R times 1 (leave Montgomery domain)
   typedef enum logic [1:0] {
      SEL_RR,
      SEL_RB,
      SEL_R1
   } opsel_t;

   // Counter must hold the value EBITS itself, hence the extra bit.
   function automatic int cnt_w(input int ebits);
      return $clog2(ebits) + 1;
   endfunction

   localparam int EBITS_DEF = 2048;
   localparam int CNT_W     = $clog2(EBITS_DEF) + 1;

endpackage

// File: rtl/mont_exp_seq.sv
// mont_exp_seq -- left-to-right binary modular exponentiation sequencer.
// Drives one external Montgomery multiplier (start/done pulses): one square
// per exponent bit, MSB first, plus one multiply by the base per set bit.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   start                 : request pulse, sampled only while busy=0
//   base_mont, one_mont   : base and 1 in Montgomery form, captured at start
//   exp, e_size           : exponent and number of bits to process (saturates at EBITS)
//   busy, done, result    : status, one-cycle done pulse, held final value
//   mm_start, mm_a, mm_b  : multiplier request pulse and registered operands
//   mm_y, mm_done         : multiplier product and completion pulse
//
// Build option: MONT_EXP_FROM_MONT_EN -- when defined, a final multiply by 1
// converts the result out of the Montgomery domain.
module mont_exp_seq
   import mont_exp_pkg::*;
#(
   parameter int NBITS = 2048,
   parameter int EBITS = 2048
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [NBITS-1:0]       base_mont,
   input  logic [NBITS-1:0]       one_mont,
   input  logic [EBITS-1:0]       exp,
   input  logic [$clog2(EBITS):0] e_size,
   output logic                   busy,
   output logic                   done,
   output logic [NBITS-1:0]       result,
   output logic                   mm_start,
   output logic [NBITS-1:0]       mm_a,
   output logic [NBITS-1:0]       mm_b,
   input  logic [NBITS-1:0]       mm_y,
   input  logic                   mm_done
);

   localparam int CW = cnt_w(EBITS);

   // State entered once the exponent bits are exhausted.
`ifdef MONT_EXP_FROM_MONT_EN
   localparam state_t END_ST = CONV_ISSUE;
`else
   localparam state_t END_ST = FIN;
`endif

   state_t            state_q, state_d;
   logic [NBITS-1:0]  r_q, r_d;
   logic [NBITS-1:0]  b_q, b_d;
   logic [EBITS-1:0]  e_q, e_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [NBITS-1:0]  mm_a_q, mm_a_d;
   logic [NBITS-1:0]  mm_b_q, mm_b_d;
   logic [NBITS-1:0]  result_q, result_d;
   logic [CW-1:0]     cnt_ld;
   opsel_t            sel;
   logic              ld_op;
   logic [NBITS-1:0]  op_a, op_b;

   always_comb begin
      state_d  = state_q;
      r_d      = r_q;
      b_d      = b_q;
      e_d      = e_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      cnt_ld   = (e_size > CW'(EBITS)) ? CW'(EBITS) : e_size;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               r_d   = one_mont;
               b_d   = base_mont;
               // Left-align so the bit under test is always e_q[EBITS-1].
               e_d   = exp << (EBITS - int'(cnt_ld));
               cnt_d = cnt_ld;
               state_d = (cnt_ld == '0) ? END_ST : SQR_ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         SQR_ISSUE: state_d = SQR_WAIT;
         SQR_WAIT: begin
            if (mm_done) begin
               r_d   = mm_y;
               cnt_d = cnt_q - CW'(1);
               e_d   = e_q << 1;
               if (e_q[EBITS-1])      state_d = MUL_ISSUE;
               else if (cnt_d == '0)  state_d = END_ST;
               else                   state_d = SQR_ISSUE;
            end
         end
         MUL_ISSUE: state_d = MUL_WAIT;
         MUL_WAIT: begin
            if (mm_done) begin
               r_d     = mm_y;
               state_d = (cnt_q == '0) ? END_ST : SQR_ISSUE;
            end
         end
         FIN:        state_d = DONE;
         CONV_ISSUE: state_d = CONV_WAIT;
         CONV_WAIT: begin
            if (mm_done) begin
               r_d     = mm_y;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d == DONE) result_d = r_d;

      // Operands load only on entry to an ISSUE state and then hold through
      // the WAIT state, so they stay stable for the multiplier's whole run.
      ld_op = 1'b1;
      sel   = SEL_RR;
      case (state_d)
         SQR_ISSUE:  sel = SEL_RR;
         MUL_ISSUE:  sel = SEL_RB;
         CONV_ISSUE: sel = SEL_R1;
         default:    ld_op = 1'b0;
      endcase

      op_a = r_d;
      op_b = r_d;
      case (sel)
         SEL_RB:  op_b = b_d;
         SEL_R1:  op_b = NBITS'(1);
         default: op_b = r_d;
      endcase

      mm_a_d = ld_op ? op_a : mm_a_q;
      mm_b_d = ld_op ? op_b : mm_b_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         r_q      <= '0;
         b_q      <= '0;
         e_q      <= '0;
         cnt_q    <= '0;
         mm_a_q   <= '0;
         mm_b_q   <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         r_q      <= r_d;
         b_q      <= b_d;
         e_q      <= e_d;
         cnt_q    <= cnt_d;
         mm_a_q   <= mm_a_d;
         mm_b_q   <= mm_b_d;
         result_q <= result_d;
      end
   end

   assign busy     = (state_q != IDLE) && (state_q != DONE);
   assign done     = (state_q == DONE);
   assign mm_start = (state_q == SQR_ISSUE) || (state_q == MUL_ISSUE) ||
                     (state_q == CONV_ISSUE);
   assign mm_a     = mm_a_q;
   assign mm_b     = mm_b_q;
   assign result   = result_q;

endmodule

// File: tb/tb_mont_exp_seq.sv
// Scoreboard bench for mont_exp_seq with NBITS=EBITS=8, p=13, k=8.
module tb_mont_exp_seq;

   localparam int NB = 8;
   localparam int EB = 8;
`ifdef MONT_EXP_FROM_MONT_EN
   localparam int CONV = 1;
`else
   localparam int CONV = 0;
`endif

   logic          clk = 1'b0;
   logic          rst, start;
   logic [NB-1:0] base_mont, one_mont, exp_i;
   logic [3:0]    e_size;
   logic          busy, done, mm_start, mm_done;
   logic [NB-1:0] result, mm_a, mm_b, mm_y;
   logic          mdl_done, spur;
   logic [NB-1:0] mdl_y;

   assign mm_done = mdl_done | spur;
   assign mm_y    = spur ? 8'hAA : mdl_y;

   mont_exp_seq #(.NBITS(NB), .EBITS(EB)) dut (
      .clk(clk), .rst(rst), .start(start), .base_mont(base_mont),
      .one_mont(one_mont), .exp(exp_i), .e_size(e_size), .busy(busy),
      .done(done), .result(result), .mm_start(mm_start), .mm_a(mm_a),
      .mm_b(mm_b), .mm_y(mm_y), .mm_done(mm_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int compared = 0, mismatched = 0;
   int pulses = 0, last_mmdone = 0;
   bit mm_start_seen;

   typedef struct {
      int res;
      int pulses;
      int start_cyc;
      int es;
   } exp_t;
   exp_t sb[$];

   task automatic chk(input string nm, input int act, input int expv);
      compared++;
      if (act !== expv) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", nm, act, expv);
      end
   endtask

   // x = base_mont / 2^8 mod 13; answer is x^n, optionally back in Montgomery form.
   function automatic int ref_res(input int bm, input int n);
      int x, v;
      x = (bm * 3) % 13;           // 3 = 2^-8 mod 13
      v = 1;
      for (int i = 0; i < n; i++) v = (v * x) % 13;
      return (CONV != 0) ? v : (v * 9) % 13;   // 9 = 2^8 mod 13
   endfunction

   // Behavioural Montgomery multiplier: a*b*2^-8 mod 13 after 3..10 cycles.
   initial begin
      int a, b, lat;
      mdl_done = 1'b0;
      mdl_y    = '0;
      forever begin
         @(negedge clk);
         if (mm_start === 1'b1) begin
            a   = int'(mm_a);
            b   = int'(mm_b);
            lat = int'($urandom_range(3, 10));
            repeat (lat) @(posedge clk);
            #1 mdl_done = 1'b1;
            mdl_y = 8'((a * b * 3) % 13);
            @(posedge clk);
            #1 mdl_done = 1'b0;
         end
      end
   end

   // Monitor: pops an expectation on every done pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            pulses = 0;
         end else begin
            if (mm_start === 1'b1) begin
               pulses++;
               mm_start_seen = 1'b1;
            end
            if (mdl_done === 1'b1) last_mmdone = cyc;
            if (done === 1'b1) begin
               if (sb.size() == 0) begin
                  chk("unexpected_done", 1, 0);
               end else begin
                  e = sb.pop_front();
                  chk("result", int'(result), e.res);
                  chk("mm_pulses", pulses, e.pulses);
                  chk("busy_at_done", int'(busy), 0);
                  if (e.es == 0 && CONV == 0) chk("done_lat_e0", cyc - e.start_cyc, 2);
                  else chk("done_lat", cyc - last_mmdone, (CONV != 0) ? 1 : 2);
               end
               pulses = 0;
            end
         end
      end
   end

   // Issues one request (called #1 after a posedge) and returns #1 into the done cycle.
   task automatic run(input int bm, input int e, input int es, input bit inject);
      exp_t x;
      int   w, ese, n;
      ese = (es > EB) ? EB : es;
      n   = e & ((1 << ese) - 1);
      w   = 0;
      while (busy === 1'b1 && w < 5000) begin
         @(posedge clk); #1;
         w++;
      end
      start     = 1'b1;
      base_mont = 8'(bm);
      exp_i     = 8'(e);
      e_size    = 4'(es);
      x.res       = ref_res(bm, n);
      x.pulses    = ese + $countones(n) + CONV;
      x.start_cyc = cyc;
      x.es        = ese;
      sb.push_back(x);
      @(posedge clk); #1;
      start     = 1'b0;
      base_mont = 8'($urandom);
      exp_i     = 8'($urandom);
      e_size    = 4'($urandom);
      chk("busy_t1", int'(busy), 1);
      chk("mm_start_t1", int'(mm_start), (ese != 0 || CONV != 0) ? 1 : 0);
      if (inject) begin
         // Extra start while busy and a done during an ISSUE/FIN cycle.
         spur  = 1'b1;
         start = 1'b1;
         @(posedge clk); #1;
         spur  = 1'b0;
         start = 1'b0;
      end
      w = 0;
      while (done !== 1'b1 && w < 5000) begin
         @(posedge clk); #1;
         w++;
      end
      chk("done_seen", int'(w < 5000), 1);
   endtask

   initial begin
      int w, seen;
      rst = 1'b1; start = 1'b0; spur = 1'b0;
      base_mont = '0; one_mont = 8'd9; exp_i = '0; e_size = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_mm_start", int'(mm_start), 0);
      chk("rst_result", int'(result), 0);
      chk("rst_mm_a", int'(mm_a), 0);
      chk("rst_mm_b", int'(mm_b), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      run(5, 5, 3, 1'b0);
      run(5, 0, 0, 1'b0);
      run(5, 8'hFF, 8, 1'b0);
      run(5, 5, 3, 1'b1);
      run(5, 8'hFF, 12, 1'b0);
      run(7, 8'hA5, 0, 1'b1);

      // Reset in MUL_WAIT of exp=5, e_size=3 (second pulse is the multiply).
      start = 1'b1; base_mont = 8'd5; exp_i = 8'd5; e_size = 4'd3;
      @(posedge clk); #1;
      start = 1'b0;
      seen = 0; w = 0;
      while (seen < 2 && w < 500) begin
         if (mm_start === 1'b1) seen++;
         if (seen < 2) begin
            @(posedge clk); #1;
         end
         w++;
      end
      chk("mul_issue_seen", seen, 2);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_mm_a", int'(mm_a), 0);
      chk("midrst_mm_b", int'(mm_b), 0);
      chk("midrst_result", int'(result), 0);
      mm_start_seen = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      chk("late_done_busy", int'(busy), 0);
      chk("late_done_no_issue", int'(mm_start_seen), 0);
      run(5, 5, 3, 1'b0);

      for (int i = 0; i < 25; i++)
         run(int'($urandom_range(0, 12)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 11)), 1'($urandom_range(0, 1)));

      @(posedge clk); #1;
      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

endmodule
